// File: rtl/uart_receiver_pkg.sv
// rtl/uart_receiver_pkg.sv - shared addresses, status bit positions and FSM states for the UART receiver
package uart_receiver_pkg;

  localparam logic [31:0] UART_RX_ADDR   = 32'h1000_0010;
  localparam logic [31:0] UART_STAT_ADDR = 32'h1000_0014;

  localparam int STAT_VALID      = 0;
  localparam int STAT_FULL       = 1;
  localparam int STAT_OVERRUN    = 2;
  localparam int STAT_FRAME_ERR  = 3;
  localparam int STAT_PARITY_ERR = 4;

  typedef enum logic [2:0] {
    URX_IDLE   = 3'd0,
    URX_START  = 3'd1,
    URX_DATA   = 3'd2,
    URX_PARITY = 3'd3,
    URX_STOP   = 3'd4,
    URX_BREAK  = 3'd5
  } urx_state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte FIFO, first-word fall-through head, count-based full/empty
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           data,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign head  = empty ? '0 : mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a push while full still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampling 8-bit UART receiver with byte FIFO and sticky error flags
// Optional even-parity framing is enabled by defining UART_RX_PARITY_EN.
module uart_receiver #(
  parameter int CLK_FREQ   = 27_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rd_data,
  output logic       rx_valid,
  output logic       rx_full,
  output logic       overrun,
  output logic       frame_err,
  output logic       parity_err
);

  import uart_receiver_pkg::*;

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW    = $clog2(OVERSAMPLE);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  urx_state_t       state, next_state;
  logic             rx_meta, rx_s, rx_prev;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [SW-1:0]    sample_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             mid_sample, bit_sample;
  logic             push, shift_en, frame_set, parity_set, overrun_set;
  logic             fifo_empty, fifo_full;
  logic [CW-1:0]    fifo_count;
`ifdef UART_RX_PARITY_EN
  logic             parity_bad;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign tick       = (div_cnt == DIV_W'(DIV - 1));
  assign mid_sample = tick && (sample_cnt == SW'(OVERSAMPLE / 2 - 1));
  assign bit_sample = tick && (sample_cnt == SW'(OVERSAMPLE - 1));

  always_comb begin
    next_state = state;
    push       = 1'b0;
    shift_en   = 1'b0;
    frame_set  = 1'b0;
    parity_set = 1'b0;
    case (state)
      URX_IDLE:  if (rx_prev && !rx_s) next_state = URX_START;
      URX_START: if (mid_sample) next_state = rx_s ? URX_IDLE : URX_DATA;
      URX_DATA: begin
        if (bit_sample) begin
          shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt == 3'd7) next_state = URX_PARITY;
`else
          if (bit_cnt == 3'd7) next_state = URX_STOP;
`endif
        end
      end
      URX_PARITY: if (bit_sample) next_state = URX_STOP;
      URX_STOP: begin
        if (bit_sample) begin
`ifdef UART_RX_PARITY_EN
          parity_set = parity_bad;
          push       = rx_s && !parity_bad;
`else
          push       = rx_s;
`endif
          frame_set  = !rx_s;
          next_state = rx_s ? URX_IDLE : URX_BREAK;
        end
      end
      URX_BREAK: if (rx_s) next_state = URX_IDLE;
      default:   next_state = URX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= URX_IDLE;
    else        state <= next_state;
  end

  // Both counters restart on every state change so each phase measures from its own origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
    end else begin
      if (state == URX_IDLE || tick) div_cnt <= '0;
      else                           div_cnt <= div_cnt + 1'b1;
      if (state == URX_IDLE || next_state != state) sample_cnt <= '0;
      else if (bit_sample)                          sample_cnt <= '0;
      else if (tick)                                sample_cnt <= sample_cnt + 1'b1;
      if (state != URX_DATA) bit_cnt <= '0;
      else if (shift_en)     bit_cnt <= bit_cnt + 1'b1;
      if (shift_en) shift_reg <= {rx_s, shift_reg[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    parity_bad <= 1'b0;
    else if (state == URX_PARITY && bit_sample)    parity_bad <= rx_s ^ even_parity(shift_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          parity_err <= 1'b0;
    else if (parity_set) parity_err <= 1'b1;
    else if (clr_err)    parity_err <= 1'b0;
  end
`else
  assign parity_err = 1'b0;
`endif

  assign overrun_set = push && (fifo_count == CW'(FIFO_DEPTH)) && !rd_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (overrun_set)  overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
      if (frame_set)    frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (rd_en),
    .data  (shift_reg),
    .head  (rd_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign rx_valid = !fifo_empty;
  assign rx_full  = fifo_full;

endmodule
